// File: rtl/platformer_pkg.sv
// Shared constants and types for the platformer game: key indices, clock/tick rates,
// and the per-key status payload produced by the input conditioner.
package platformer_pkg;

  localparam int unsigned KEY_RIGHT = 0;
  localparam int unsigned KEY_JUMP  = 1;
  localparam int unsigned KEY_LEFT  = 2;
  localparam int unsigned KEY_SPARE = 3;

  localparam int unsigned CLK_HZ       = 50_000_000;
  localparam int unsigned TICK_DIV_MAX = 833_333;

  // 10 ms of stable level at CLK_HZ before a key change is believed
  localparam int unsigned DEBOUNCE_CYCLES_DEF = CLK_HZ / 100;
  localparam int unsigned DEBOUNCE_CNT_W      = 20;

  // Stable key state kept in the pins' active-low sense
  typedef enum logic {
    KEY_HELD     = 1'b0,
    KEY_RELEASED = 1'b1
  } key_state_e;

  typedef struct packed {
    logic level;
    logic press_pend;
    logic release_pend;
  } key_status_t;

endpackage

// File: rtl/input_conditioner_key_debounce.sv
// One key channel: two-flop synchronizer, counter debouncer, registered level,
// and sticky press/release pendings that are consumed by game_tick.
module key_debounce
  import platformer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = DEBOUNCE_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_tick,
  input  logic        i_key_n,
  output key_status_t o_status
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  key_state_e       r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press_pend;
  logic             r_release_pend;

  logic             w_differs;
  logic             w_flip;
  key_state_e       w_stable_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_press_nxt;
  logic             w_release_nxt;

  // Synchronizer: straight flop-to-flop, idles released
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive disagreeing cycles; accept the new level at the terminal count
  always_comb begin
    w_cnt_nxt    = '0;
    w_stable_nxt = r_stable;
    w_flip       = 1'b0;
    w_differs    = (r_sync2 != logic'(r_stable));
    if (w_differs) begin
      if (r_cnt == TERM) begin
        w_flip       = 1'b1;
        w_stable_nxt = key_state_e'(r_sync2);
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  // A debounced edge sets its pending even when a tick would clear it that cycle
  always_comb begin
    w_press_nxt   = r_press_pend;
    w_release_nxt = r_release_pend;
    if (i_tick) begin
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
    end
    if (w_flip && (w_stable_nxt == KEY_HELD)) begin
      w_press_nxt = 1'b1;
    end
    if (w_flip && (w_stable_nxt == KEY_RELEASED)) begin
      w_release_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stable       <= KEY_RELEASED;
      r_cnt          <= '0;
      r_level        <= 1'b0;
      r_press_pend   <= 1'b0;
      r_release_pend <= 1'b0;
    end else begin
      r_stable       <= w_stable_nxt;
      r_cnt          <= w_cnt_nxt;
      r_level        <= (r_stable == KEY_HELD);
      r_press_pend   <= w_press_nxt;
      r_release_pend <= w_release_nxt;
    end
  end

  assign o_status = '{level: r_level, press_pend: r_press_pend, release_pend: r_release_pend};

endmodule

// File: rtl/input_conditioner.sv
// Conditions the raw active-low push-buttons for the game logic: one debounce channel
// per key, with press/release events presented only on game_tick cycles.
module input_conditioner
  import platformer_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = DEBOUNCE_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                game_tick,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                any_level
);

  key_status_t w_status [NUM_KEYS];

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_key_debounce (
      .clk     (clk),
      .rst     (rst),
      .i_tick  (game_tick),
      .i_key_n (key_n[g]),
      .o_status(w_status[g])
    );
  end

  // Events are visible only while the tick strobe is high
  always_comb begin
    key_level   = '0;
    key_press   = '0;
    key_release = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      key_level[k]   = w_status[k].level;
      key_press[k]   = w_status[k].press_pend & game_tick;
      key_release[k] = w_status[k].release_pend & game_tick;
    end
  end

  assign any_level = |key_level;

endmodule
